// File: rtl/servo_bank_pkg.sv
// Shared types and helpers for the servo_bank PWM generator.
package servo_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } calc_state_t;

    function automatic int us_to_cyc(input int us, input int freq);
        return us * (freq / 32'd1_000_000);
    endfunction

endpackage

// File: rtl/servo_width_calc.sv
// Combinational angle-to-pulse-width mapping, time-shared across all channels.
// With SERVO_BANK_SLEW_EN defined it also produces the slew-limited next angle.
module servo_width_calc
    import servo_pkg::*;
#(
    parameter int ANGLE_W = 8,
    parameter int CNT_W   = 10,
    parameter int MIN_CYC = 10,
    parameter int MAX_CYC = 20
`ifdef SERVO_BANK_SLEW_EN
    ,
    parameter int SLEW_STEP = 4
`endif
) (
    input  logic [ANGLE_W-1:0] target,
`ifdef SERVO_BANK_SLEW_EN
    input  logic [ANGLE_W-1:0] cur,
    output logic [ANGLE_W-1:0] cur_next,
`endif
    output logic [CNT_W-1:0]   width
);

    localparam int PROD_W = ANGLE_W + $clog2(MAX_CYC);
    localparam int SPAN   = MAX_CYC - MIN_CYC;
    localparam int FULL   = (2 ** ANGLE_W) - 1;

    logic [ANGLE_W-1:0] angle_s;
    logic [PROD_W-1:0]  prod_s;
    logic [PROD_W-1:0]  quot_s;

`ifdef SERVO_BANK_SLEW_EN
    // Step the current angle toward target without overshooting it.
    always_comb begin
        cur_next = cur;
        if (target > cur) begin
            if ((target - cur) > ANGLE_W'(SLEW_STEP)) begin
                cur_next = cur + ANGLE_W'(SLEW_STEP);
            end else begin
                cur_next = target;
            end
        end else begin
            if ((cur - target) > ANGLE_W'(SLEW_STEP)) begin
                cur_next = cur - ANGLE_W'(SLEW_STEP);
            end else begin
                cur_next = target;
            end
        end
    end
    assign angle_s = cur_next;
`else
    assign angle_s = target;
`endif

    // Linear map with floor division; the product width cannot overflow.
    always_comb begin
        prod_s = PROD_W'(angle_s) * PROD_W'(SPAN);
        quot_s = prod_s / PROD_W'(FULL);
        width  = CNT_W'(MIN_CYC) + CNT_W'(quot_s);
    end

endmodule

// File: rtl/servo_bank.sv
// Multi-channel servo PWM bank: shared frame counter, end-of-frame width calculation,
// widths and enables latched at frame wrap. Optional slew limiting: SERVO_BANK_SLEW_EN.
module servo_bank
    import servo_pkg::*;
#(
    parameter int FREQ      = 50_000_000,
    parameter int CHANNELS  = 4,
    parameter int ANGLE_W   = 8,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 1000,
    parameter int MAX_US    = 2000,
    parameter int SLEW_STEP = 4,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [ANGLE_W-1:0]  wr_angle,
    input  logic [CHANNELS-1:0] enable,
    output logic [CHANNELS-1:0] servo_pwm,
    output logic                cycle_done
);

    localparam int PERIOD_CYC = us_to_cyc(PERIOD_US, FREQ);
    localparam int MIN_CYC    = us_to_cyc(MIN_US, FREQ);
    localparam int MAX_CYC    = us_to_cyc(MAX_US, FREQ);
    localparam int CNT_W      = $clog2(PERIOD_CYC);

    if ((PERIOD_CYC - MAX_CYC < CHANNELS + 2) || (MAX_CYC <= MIN_CYC) || (SLEW_STEP < 1)) begin : g_bad_cfg
        $error("servo_bank: inconsistent timing parameters");
    end

    logic [CNT_W-1:0]   counter_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               wrap_s;
    calc_state_t        state_r;
    logic [CH_W-1:0]    calc_ch_r;
    logic [ANGLE_W-1:0] target_r     [CHANNELS];
    logic [CNT_W-1:0]   pending_r    [CHANNELS];
    logic [CNT_W-1:0]   pending_next_s [CHANNELS];
    logic [CNT_W-1:0]   active_w_r   [CHANNELS];
    logic [CHANNELS-1:0] active_en_r;
    logic [CNT_W-1:0]   calc_width_s;
`ifdef SERVO_BANK_SLEW_EN
    logic [ANGLE_W-1:0] cur_r [CHANNELS];
    logic [ANGLE_W-1:0] cur_next_s;
`endif

    assign wrap_s     = (counter_r == CNT_W'(PERIOD_CYC - 1));
    assign cnt_next_s = wrap_s ? {CNT_W{1'b0}} : counter_r + CNT_W'(1);

    servo_width_calc #(
        .ANGLE_W (ANGLE_W),
        .CNT_W   (CNT_W),
        .MIN_CYC (MIN_CYC),
        .MAX_CYC (MAX_CYC)
`ifdef SERVO_BANK_SLEW_EN
        ,
        .SLEW_STEP (SLEW_STEP)
`endif
    ) u_width_calc (
        .target   (target_r[calc_ch_r]),
`ifdef SERVO_BANK_SLEW_EN
        .cur      (cur_r[calc_ch_r]),
        .cur_next (cur_next_s),
`endif
        .width    (calc_width_s)
    );

    // Calc sequencer: one channel per cycle in the slots just before the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            calc_ch_r <= {CH_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    calc_ch_r <= {CH_W{1'b0}};
                    if (counter_r == CNT_W'(PERIOD_CYC - CHANNELS - 1)) begin
                        state_r <= CALC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    if (calc_ch_r == CH_W'(CHANNELS - 1)) begin
                        state_r   <= IDLE;
                        calc_ch_r <= {CH_W{1'b0}};
                    end else begin
                        calc_ch_r <= calc_ch_r + CH_W'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    calc_ch_r <= {CH_W{1'b0}};
                end
            endcase
        end
    end

    // Last channel is computed on the wrap edge itself, so the wrap copies the next value.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            if ((state_r == CALC) && (calc_ch_r == CH_W'(i))) begin
                pending_next_s[i] = calc_width_s;
            end else begin
                pending_next_s[i] = pending_r[i];
            end
        end
    end

    // Target and pending registers (plus current angle under slew limiting).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                target_r[i]  <= {ANGLE_W{1'b0}};
                pending_r[i] <= {CNT_W{1'b0}};
`ifdef SERVO_BANK_SLEW_EN
                cur_r[i]     <= {ANGLE_W{1'b0}};
`endif
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pending_r[i] <= pending_next_s[i];
            end
`ifdef SERVO_BANK_SLEW_EN
            if (state_r == CALC) begin
                cur_r[calc_ch_r] <= cur_next_s;
            end
`endif
            if (wr_en && (32'(wr_ch) < CHANNELS)) begin
                target_r[wr_ch] <= wr_angle;
            end
        end
    end

    // Frame counter, frame latch and registered PWM outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_r   <= {CNT_W{1'b0}};
            cycle_done  <= 1'b0;
            servo_pwm   <= {CHANNELS{1'b0}};
            active_en_r <= {CHANNELS{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                active_w_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            counter_r  <= cnt_next_s;
            cycle_done <= wrap_s;
            if (wrap_s) begin
                active_en_r <= enable;
                for (int i = 0; i < CHANNELS; i++) begin
                    active_w_r[i] <= pending_next_s[i];
                    servo_pwm[i]  <= enable[i] && (pending_next_s[i] != {CNT_W{1'b0}});
                end
            end else begin
                for (int i = 0; i < CHANNELS; i++) begin
                    servo_pwm[i] <= active_en_r[i] && (cnt_next_s < active_w_r[i]);
                end
            end
        end
    end

endmodule

// File: doc/servo_bank.md
SERVO_BANK -- requirements
Module: servo_bank

Interface
REQ-001 SHALL have parameter FREQ, 50_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter CHANNELS, 4, number of independent servo outputs (1..16).
REQ-003 SHALL have parameter ANGLE_W, 8, angle word width in bits.
REQ-004 SHALL have parameter PERIOD_US, 20000, PWM frame period in microseconds.
REQ-005 SHALL have parameters MIN_US, 1000, and MAX_US, 2000, which are the pulse widths at angle 0 and angle all-ones.
REQ-006 SHALL have parameter SLEW_STEP, 4, maximum angle change per frame when slew limiting is compiled in.
REQ-007 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port wr_en  input  1  write strobe for one channel's target angle.
REQ-010 SHALL have port wr_ch  input  clog2(CHANNELS) (min 1)  channel index for the write.
REQ-011 SHALL have port wr_angle  input  ANGLE_W  target angle.
REQ-012 SHALL have port enable  input  CHANNELS  per-channel output enable.
REQ-013 SHALL have port servo_pwm  output  CHANNELS  registered PWM outputs.
REQ-014 SHALL have port cycle_done  output  1  one-cycle frame-start pulse.

Function
REQ-015 SHALL derive constants: CYC_US = FREQ/1_000_000; PERIOD_CYC = PERIOD_US*CYC_US; MIN_CYC = MIN_US*CYC_US; MAX_CYC = MAX_US*CYC_US. Elaboration SHALL fail unless PERIOD_CYC - MAX_CYC >= CHANNELS+2 and MAX_CYC > MIN_CYC.
REQ-016 SHALL run one shared frame counter 0..PERIOD_CYC-1. It SHALL wrap to 0.
REQ-017 On wr_en, SHALL store wr_angle into the target register of channel wr_ch in the same cycle. An out-of-range wr_ch SHALL be ignored.
REQ-018 SHALL run a calc FSM with states IDLE -> CALC -> IDLE:
- It SHALL enter CALC when counter == PERIOD_CYC-CHANNELS-1.
- It SHALL process channel i at counter == PERIOD_CYC-CHANNELS+i, one channel per cycle.
- It SHALL return to IDLE after the last channel.
REQ-019 For each channel in CALC, SHALL compute pending width = MIN_CYC + (angle*(MAX_CYC-MIN_CYC)) / (2^ANGLE_W-1):
- floor division;
- intermediate width ANGLE_W + clog2(MAX_CYC) bits, with no overflow.
REQ-020 In CALC, angle SHALL be the target register value as it stands before the processing cycle. A write in that same cycle SHALL take effect in the following frame.
REQ-021 At the wrap to 0, SHALL copy pending widths to active widths and sample enable into the active enables.
REQ-022 servo_pwm[i] SHALL be 1 exactly while active_en[i] && counter < active_width[i]. That gives exactly active_width[i] high cycles per frame, with no runt or split pulses.
REQ-023 An enable change mid-frame SHALL have no effect until the next wrap.
REQ-024 cycle_done SHALL pulse high for one cycle at each counter wrap to 0. It SHALL be coincident with the rising edges of the servo_pwm outputs.
REQ-025 Write-to-output latency SHALL be at most two frames. A write before the channel's CALC cycle SHALL appear in the next frame.

Reset
REQ-026 While rst_n is low, SHALL hold: servo_pwm=0, cycle_done=0, counter=0, FSM=IDLE, all target, pending and active widths and enables=0.
REQ-027 After release, the first frame SHALL output all-low. The first cycle_done SHALL occur at the first wrap, not at release.
REQ-028 Reset asserted mid-frame or mid-CALC SHALL force all outputs low immediately (asynchronously).

Configuration
REQ-029 Macro SERVO_BANK_SLEW_EN:
- When defined, SHALL keep a per-channel current angle. In each channel's CALC cycle it SHALL move toward target by at most SLEW_STEP, with no overshoot, and use it in the width formula. Current angle SHALL reset to 0.
- When undefined, the width SHALL use the target directly and no current-angle registers SHALL exist.

Structure
REQ-030 Package servo_pkg SHALL hold the FSM state typedef (IDLE, CALC) and the us-to-cycles constant function.
REQ-031 Sub-module servo_width_calc SHALL be used: combinational angle-to-width mapping (plus the slew step when enabled), instanced once and time-shared across channels.

Verification (FREQ=1_000_000, PERIOD_US=100, MIN_US=10, MAX_US=20, CHANNELS=4, ANGLE_W=8)
REQ-032 Reset then release, no writes -> frame 1 all servo_pwm low; cycle_done first high at cycle 100.
REQ-033 Write ch0=0, ch1=255, ch2=128, enable=4'b0111 in frame 1 -> frame 2 high widths 10, 20, 15 cycles; ch3 stays low.
REQ-034 Write ch1=0 during ch1's CALC cycle (counter 97) -> next frame still 20; the frame after that 10.
REQ-035 Drop enable[0] at counter 5 -> current pulse stays 10 cycles; next frame low.
REQ-036 Assert rst_n low at counter 7 mid-pulse -> servo_pwm=0 immediately; after release, one all-low frame.
REQ-037 With SERVO_BANK_SLEW_EN and SLEW_STEP=64, write ch0 0->255 -> successive widths 12, 15, 17, 20 (angles 64, 128, 192, 255).
